regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (writeReg/writeData) among NUM_REQ write-back requesters, e.g. ALU result, load result and multiply/divide unit.
- Each requester uses a valid/ready handshake. One request is granted per cycle by round-robin; the winner is presented to the register file through a registered output stage.
- Sits between the execute/memory write-back sources and the register file. Writes to register 0 are absorbed without using the port.

Parameters:
- NUM_REQ, 3, number of write-back requesters, legal range 2..8.
- REG_AW, 5, register address width.
- DATA_W, 32, write data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_reg  in  NUM_REQ*REG_AW  flattened destination registers; requester i uses bits [i*REG_AW +: REG_AW].
- req_data  in  NUM_REQ*DATA_W  flattened write data; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- wr_reg  out  REG_AW  to register file writeReg; 0 means no write.
- wr_data  out  DATA_W  to register file writeData.
- busy  out  1  registered; high when any requester lost arbitration this cycle.
- grant_idx  out  3  registered index of the last granted requester.

Behaviour:
- Reset: asynchronous, active-high. Clears wr_reg=0, wr_data=0, busy=0, grant_idx=0, and sets the round-robin pointer so requester 0 has top priority. Reset asserted mid-operation drops any in-flight registered write; no write is issued on the edge rst deasserts.
- Handshake: transfer on requester i occurs in a cycle where req_valid[i] && req_ready[i]. Once asserted, a requester holds req_valid, req_reg and req_data stable until accepted. req_ready never depends on the same requester's req_data.
- Zero register: a valid request with req_reg==0 gets req_ready=1 in the same cycle, regardless of arbitration. It consumes no grant and produces no write.
- Arbitration: among valid requests with nonzero req_reg, exactly one wins per cycle.
  - The search starts at index ptr and proceeds ptr, ptr+1, ... modulo NUM_REQ.
  - The winner gets req_ready=1; all other nonzero requesters get req_ready=0.
  - On a grant, ptr becomes (winner+1) mod NUM_REQ. ptr is unchanged when nothing is granted.
- Latency: the winner's req_reg/req_data appear on wr_reg/wr_data at the next rising edge, so the register file writes one cycle after the handshake. In cycles with no grant, wr_reg=0 on the next edge; wr_data holds its previous value.
- Throughput: one write per cycle sustained. No internal queue beyond the single output register, so no full/empty condition exists.
- busy: registered. Set on the next edge if at least one nonzero valid request was not granted this cycle, otherwise cleared.
- grant_idx: updated on a grant only.
- Same destination in one cycle: the two requests are serialized in arbitration order; the later-granted value is the final register contents. Ordering between different requesters is defined solely by grant order.
- Starvation bound: a held request is granted within NUM_REQ cycles.
- Combinational path: req_valid/req_reg to req_ready only; no path from inputs to wr_reg/wr_data.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- When defined: ptr is ignored and held at 0. Lowest index always wins, and the starvation bound does not apply.
- When undefined: round-robin as above.
- grant_idx, busy and the zero-register rule are identical in both modes.

Test Plan:
- Reset, then idle; assert rst mid-stream -> wr_reg=0, wr_data=0, busy=0, grant_idx=0; no write after deassert.
- Requester 1 alone: reg=7, data=0xDEADBEEF -> req_ready[1]=1 same cycle; next edge wr_reg=7, wr_data=0xDEADBEEF; following cycle wr_reg=0.
- All 3 valid continuously, regs 3/4/5, ptr=0 after reset -> grants 0,1,2,0,... on consecutive cycles; wr_reg sequence 3,4,5,3; busy=1 while the others wait.
- Requester 0 reg=0 together with requester 2 reg=9, data=0x55 -> both ready the same cycle; only wr_reg=9, wr_data=0x55 is issued; ptr advances past 2.
- Requesters 0 and 1 both target reg 6 with data 0x11 and 0x22 -> two writes in grant order; register 6 ends with the later-granted value.
- With WB_FIXED_PRIO_EN, requesters 0 and 2 held valid -> requester 0 granted every cycle; requester 2 granted only after req_valid[0] drops.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file's single write port among NUM_REQ
//               write-back requesters (e.g. ALU, load, mul/div). Each
//               requester uses a valid/ready handshake. One nonzero-destination
//               request is granted per cycle by round-robin. The winner is
//               presented to the register file through a registered stage.
//               Requests that target register 0 are accepted immediately.
//               They consume no grant and produce no write.
//
// Ports       : clk        - clock; all state updates on the rising edge
//               rst        - asynchronous, active-high reset
//               req_valid  - [NUM_REQ] per-requester request valid
//               req_reg    - [NUM_REQ*REG_AW] flattened destination registers
//               req_data   - [NUM_REQ*DATA_W] flattened write data
//               req_ready  - [NUM_REQ] per-requester accept (combinational)
//               wr_reg     - register file writeReg (0 = no write), registered
//               wr_data    - register file writeData, registered
//               busy       - registered; a nonzero request lost arbitration
//               grant_idx  - registered index of the last granted requester
//
// Options     : WB_FIXED_PRIO_EN - when defined, the lowest index always wins
//               (the round-robin pointer is held at 0).
//
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,   // legal range 2..8
    parameter int REG_AW  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*REG_AW-1:0]  req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [REG_AW-1:0]          wr_reg,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       busy,
    output logic [2:0]                 grant_idx
);

    localparam logic [3:0] c_NUM  = 4'(NUM_REQ);
    localparam logic [2:0] c_LAST = 3'(NUM_REQ - 1);

    // Registered state
    logic [2:0]        r_ptr;
    logic [REG_AW-1:0] r_wrReg;
    logic [DATA_W-1:0] r_wrData;
    logic              r_busy;
    logic [2:0]        r_grantIdx;

    // Combinational arbitration signals
    logic [NUM_REQ-1:0] w_zero;
    logic [NUM_REQ-1:0] w_nonZero;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_found;
    logic [2:0]         w_win;
    logic [3:0]         w_cand;
    logic [REG_AW-1:0]  w_selReg;
    logic [DATA_W-1:0]  w_selData;
    logic               w_lost;
    logic [2:0]         w_ptrNext;

    // Per-requester classification and ready generation. A register-0 request
    // is ready as soon as it is valid, independent of arbitration.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_zero[gi]    = (req_reg[gi*REG_AW +: REG_AW] == '0);
            assign w_nonZero[gi] = req_valid[gi] & ~w_zero[gi];
            assign w_grant[gi]   = w_found && (w_win == 3'(gi));
            assign req_ready[gi] = req_valid[gi] & (w_zero[gi] | w_grant[gi]);
        end
    endgenerate

    // Round-robin search: candidates are visited in order ptr, ptr+1, ...
    // wrapping at NUM_REQ. The first nonzero valid request wins. Only
    // constant slices of the flattened buses are used, so the data mux is
    // built from the same loop.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_cand    = '0;
        w_selReg  = '0;
        w_selData = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + 4'(k);
            if (w_cand >= c_NUM) begin
                w_cand = w_cand - c_NUM;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && w_nonZero[i] && (w_cand == 4'(i))) begin
                    w_found   = 1'b1;
                    w_win     = 3'(i);
                    w_selReg  = req_reg[i*REG_AW +: REG_AW];
                    w_selData = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // A loser exists when any nonzero valid request did not get the grant.
    assign w_lost = |(w_nonZero & ~w_grant);

`ifdef WB_FIXED_PRIO_EN
    // Fixed priority: search always starts at requester 0.
    assign w_ptrNext = 3'd0;
`else
    assign w_ptrNext = (w_win == c_LAST) ? 3'd0 : (w_win + 3'd1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= 3'd0;
            r_wrReg    <= '0;
            r_wrData   <= '0;
            r_busy     <= 1'b0;
            r_grantIdx <= 3'd0;
        end else begin
            r_busy <= w_lost;
            if (w_found) begin
                r_ptr      <= w_ptrNext;
                r_wrReg    <= w_selReg;
                r_wrData   <= w_selData;
                r_grantIdx <= w_win;
            end else begin
                // No grant: no write this cycle, data simply holds.
                r_wrReg <= '0;
            end
        end
    end

    assign wr_reg    = r_wrReg;
    assign wr_data   = r_wrData;
    assign busy      = r_busy;
    assign grant_idx = r_grantIdx;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter (NUM_REQ=3,
//               REG_AW=5, DATA_W=32). A behavioural model predicts the ready
//               vector each cycle and the registered outputs after each edge.
//               Directed scenarios add literal expectations. Inputs change
//               1 time unit after the rising edge; outputs are compared on
//               the falling edge. Honours WB_FIXED_PRIO_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_reg   = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   wr_reg;
    logic [DW-1:0]   wr_data;
    logic            busy;
    logic [2:0]      grant_idx;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.NUM_REQ(N), .REG_AW(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setReq(input int i, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_reg[i*AW +: AW]   = r;
        req_data[i*DW +: DW]  = d;
    endtask

    // Register file driven by the DUT write port
    logic [DW-1:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) if (!rst && wr_reg != '0) rf[wr_reg] <= wr_data;

    // ---------------- Behavioural model ----------------
    int            mPtr = 0;
    logic [AW-1:0] mWrReg = '0;
    logic [DW-1:0] mWrData = '0;
    logic          mBusy = 1'b0;
    int            mGrant = 0;
    // values that become visible after the next rising edge
    int            pPtr = 0;
    logic [AW-1:0] pWrReg = '0;
    logic [DW-1:0] pWrData = '0;
    logic          pBusy = 1'b0;
    int            pGrant = 0;

    always @(negedge clk) begin
        int            winner;
        int            idx;
        logic [N-1:0]  expReady;
        logic          anyLoser;
        logic [AW-1:0] r;
        if (rst) begin
            mPtr = 0; mWrReg = '0; mWrData = '0; mBusy = 1'b0; mGrant = 0;
            pPtr = 0; pWrReg = '0; pWrData = '0; pBusy = 1'b0; pGrant = 0;
            chk("model_rst_wr_reg", 64'(wr_reg), 64'd0);
            chk("model_rst_busy", 64'(busy), 64'd0);
        end else begin
            // registered outputs against the model state
            chk("model_wr_reg", 64'(wr_reg), 64'(mWrReg));
            chk("model_wr_data", 64'(wr_data), 64'(mWrData));
            chk("model_busy", 64'(busy), 64'(mBusy));
            chk("model_grant_idx", 64'(grant_idx), 64'(mGrant));
            // arbitration from the rules: first nonzero valid from ptr onward
            winner = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mPtr + k) % N;
                if (winner < 0 && req_valid[idx] && req_reg[idx*AW +: AW] != '0) winner = idx;
            end
            anyLoser = 1'b0;
            for (int i = 0; i < N; i++) begin
                r = req_reg[i*AW +: AW];
                expReady[i] = req_valid[i] && (r == '0 || i == winner);
                if (req_valid[i] && r != '0 && i != winner) anyLoser = 1'b1;
            end
            chk("model_req_ready", 64'(req_ready), 64'(expReady));
            pBusy = anyLoser;
            if (winner >= 0) begin
                pWrReg  = req_reg[winner*AW +: AW];
                pWrData = req_data[winner*DW +: DW];
                pGrant  = winner;
`ifdef WB_FIXED_PRIO_EN
                pPtr = 0;
`else
                pPtr = (winner + 1) % N;
`endif
            end else begin
                pWrReg  = '0;
                pWrData = mWrData;
                pGrant  = mGrant;
                pPtr    = mPtr;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            mPtr = pPtr; mWrReg = pWrReg; mWrData = pWrData; mBusy = pBusy; mGrant = pGrant;
        end
    end

    // Hold requests until each one is accepted, bounded.
    task automatic holdUntilAccepted(input string name);
        logic [N-1:0] acc;
        int           n;
        n = 0;
        while (req_valid != '0 && n < 8) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~acc;
            n++;
        end
        chk({name, "_accept_timeout"}, 64'(req_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        // ---------------- Reset / idle ----------------
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_wr_reg", 64'(wr_reg), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_grant_idx", 64'(grant_idx), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // ---------------- Requester 1 alone ----------------
        setReq(1, 1'b1, 5'd7, 32'hDEADBEEF);
        @(negedge clk);
        chk("solo_ready", 64'(req_ready), 64'b010);
        @(posedge clk); #1;
        setReq(1, 1'b0, 5'd0, 32'h0);
        chk("solo_wr_reg", 64'(wr_reg), 64'd7);
        chk("solo_wr_data", 64'(wr_data), 64'hDEADBEEF);
        chk("solo_grant_idx", 64'(grant_idx), 64'd1);
        chk("solo_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("solo_idle_wr_reg", 64'(wr_reg), 64'd0);
        chk("solo_idle_wr_data_hold", 64'(wr_data), 64'hDEADBEEF);

        // reset returns the pointer to requester 0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

`ifndef WB_FIXED_PRIO_EN
        // ---------------- All three contending ----------------
        begin
            logic [N-1:0]  rdyExp [4];
            logic [AW-1:0] regExp [4];
            rdyExp = '{3'b001, 3'b010, 3'b100, 3'b001};
            regExp = '{5'd3, 5'd4, 5'd5, 5'd3};
            setReq(0, 1'b1, 5'd3, 32'h100);
            setReq(1, 1'b1, 5'd4, 32'h200);
            setReq(2, 1'b1, 5'd5, 32'h300);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk("rr_ready", 64'(req_ready), 64'(rdyExp[c]));
                @(posedge clk); #1;
                chk("rr_wr_reg", 64'(wr_reg), 64'(regExp[c]));
                chk("rr_busy", 64'(busy), 64'd1);
            end
            req_valid = '0;
        end
        // pointer is now 1 (last winner 0)

        // ---------------- Zero-register request alongside a real one ----------------
        setReq(0, 1'b1, 5'd0, 32'hAA);
        setReq(2, 1'b1, 5'd9, 32'h55);
        @(negedge clk);
        chk("zero_ready", 64'(req_ready), 64'b101);
        @(posedge clk); #1;
        req_valid = '0;
        chk("zero_wr_reg", 64'(wr_reg), 64'd9);
        chk("zero_wr_data", 64'(wr_data), 64'h55);
        chk("zero_grant_idx", 64'(grant_idx), 64'd2);
        chk("zero_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("zero_no_second_write", 64'(wr_reg), 64'd0);
`endif

        // ---------------- Same destination from two requesters ----------------
        setReq(0, 1'b1, 5'd6, 32'h11);
        setReq(1, 1'b1, 5'd6, 32'h22);
        holdUntilAccepted("samedst");
        chk("samedst_grant_idx", 64'(grant_idx), 64'd1);
        @(posedge clk); #1;
        chk("samedst_rf6", 64'(rf[6]), 64'h22);

        // ---------------- Reset mid-stream ----------------
        setReq(0, 1'b1, 5'd3, 32'h100);
        setReq(1, 1'b1, 5'd4, 32'h200);
        setReq(2, 1'b1, 5'd5, 32'h300);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("midrst_wr_reg", 64'(wr_reg), 64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_grant_idx", 64'(grant_idx), 64'd0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_write_after", 64'(wr_reg), 64'd0);
        setReq(1, 1'b1, 5'd10, 32'hA0);
        setReq(2, 1'b1, 5'd11, 32'hB0);
        @(negedge clk);
        chk("midrst_ptr0_ready", 64'(req_ready), 64'b010);
        holdUntilAccepted("midrst");

`ifdef WB_FIXED_PRIO_EN
        // ---------------- Fixed priority ----------------
        setReq(0, 1'b1, 5'd1, 32'h1);
        setReq(2, 1'b1, 5'd2, 32'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("fixed_ready", 64'(req_ready), 64'b001);
            @(posedge clk); #1;
            chk("fixed_grant_idx", 64'(grant_idx), 64'd0);
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("fixed_ready_after_drop", 64'(req_ready), 64'b100);
        @(posedge clk); #1;
        req_valid = '0;
        chk("fixed_grant_idx_2", 64'(grant_idx), 64'd2);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
